// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver; latches the glyph word once per frame.
// Optional digit blinking is enabled by defining DISP_BLINK_EN.
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] codes_i,
  input  logic [3:0]  dp_in_i,
  input  logic [3:0]  blink_mask_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        frame_start_o
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam bit INV = (ACTIVE_LOW != 0);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [19:0]   word_q, word_d;
  logic [3:0]    dpl_q, dpl_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          fs_q;
  logic          tick, latch;
  logic [4:0]    code;
  logic [3:0]    an_hi;
  logic          blank_an;

  function automatic logic [6:0] glyph(input logic [4:0] c);
    logic [6:0] s;
    case (c)
      5'd0:  s = 7'b0111111;
      5'd1:  s = 7'b0000110;
      5'd2:  s = 7'b1011011;
      5'd3:  s = 7'b1001111;
      5'd4:  s = 7'b1100110;
      5'd5:  s = 7'b1101101;
      5'd6:  s = 7'b1111101;
      5'd7:  s = 7'b0000111;
      5'd8:  s = 7'b1111111;
      5'd9:  s = 7'b1101111;
      5'd10: s = 7'b1110111;
      5'd11: s = 7'b1111100;
      5'd12: s = 7'b0111001;
      5'd13: s = 7'b1011110;
      5'd14: s = 7'b1111001;
      5'd15: s = 7'b1110001;
      5'd16: s = 7'b1110110;
      5'd17: s = 7'b0011110;
      5'd18: s = 7'b0111000;
      5'd19: s = 7'b1010100;
      5'd20: s = 7'b1110011;
      5'd21: s = 7'b1010000;
      5'd22: s = 7'b1011100;
      5'd23: s = 7'b1111000;
      5'd24: s = 7'b0011100;
      5'd25: s = 7'b1101101;
      5'd26: s = 7'b1000000;
      5'd27: s = 7'b0001000;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  assign tick  = (presc_q == PW'(SCAN_DIV - 1));
  assign latch = tick && (idx_q == 2'd3);
  assign code  = word_q[5*int'(idx_q) +: 5];

`ifdef DISP_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    mask_q, mask_d;

  // phase flips after every BLINK_FRAMES latched frames
  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    mask_d  = mask_q;
    if (latch) begin
      mask_d = blink_mask_i;
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q  <= '0;
      phase_q <= 1'b0;
      mask_q  <= '0;
    end else begin
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
      mask_q  <= mask_d;
    end
  end

  assign blank_an = phase_q && mask_q[idx_q];
`else
  logic unused_blink;
  assign unused_blink = (^blink_mask_i) ^ (BLINK_FRAMES > 0);
  assign blank_an     = 1'b0;
`endif

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
    word_d  = latch ? codes_i : word_q;
    dpl_d   = latch ? dp_in_i : dpl_q;
    an_hi   = blank_an ? 4'b0000 : (4'b0001 << idx_q);
    an_d    = INV ? ~an_hi : an_hi;
    seg_d   = INV ? ~glyph(code) : glyph(code);
    dp_d    = INV ? ~dpl_q[idx_q] : dpl_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      dpl_q   <= '0;
      an_q    <= INV ? 4'hF : 4'h0;
      seg_q   <= INV ? 7'h7F : 7'h00;
      dp_q    <= INV;
      fs_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      dpl_q   <= dpl_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fs_q    <= latch;
    end
  end

  assign an_o          = an_q;
  assign seg_o         = seg_q;
  assign dp_o          = dp_q;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: cycle-count reference model with random glyph traffic.
// Build with +define+DISP_BLINK_EN to check the blink feature.
module tb_seg7_scan_driver;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] codes = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  mask = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        fs;

  seg7_scan_driver #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .codes_i(codes), .dp_in_i(dp_in),
    .blink_mask_i(mask), .an_o(an), .seg_o(seg), .dp_o(dp),
    .frame_start_o(fs)
  );

  always #5 clk = ~clk;

  logic [6:0]  seg_tab [32];
  int          n;
  int          k;
  logic [19:0] m_codes;
  logic [3:0]  m_dp;
  logic [3:0]  m_mask;
  int          checks = 0;
  int          passed = 0;

  task automatic chk(input string tag, input logic [12:0] got,
                     input logic [12:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
  endtask

  // One clock: expected output reflects the model state before the edge
  task automatic step(input string tag);
    int         idx;
    bit         ph;
    bit         fr;
    logic [3:0] a;
    logic [4:0] c;
    logic [12:0] e;
    @(posedge clk);
    n++;
    idx = ((n - 1) / SD) % 4;
`ifdef DISP_BLINK_EN
    ph = ((k / BF) % 2) == 1;
`else
    ph = 1'b0;
`endif
    a = (ph && m_mask[idx]) ? 4'b0000 : (4'b0001 << idx);
    c = m_codes[5*idx +: 5];
    fr = (n % FR) == 0;
    e = {~a, ~seg_tab[c], ~m_dp[idx], fr};
    if (fr) begin
      m_codes = codes;
      m_dp    = dp_in;
      m_mask  = mask;
      k++;
    end
    #1 chk(tag, {an, seg, dp, fs}, e);
  endtask

  task automatic reset_for(input int cyc);
    rst = 1'b1;
    repeat (cyc) begin
      @(posedge clk);
      #1 chk("reset", {an, seg, dp, fs}, {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    rst = 1'b0;
    n = 0; k = 0;
    m_codes = '0; m_dp = '0; m_mask = '0;
  endtask

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
                7'h76, 7'h1E, 7'h38, 7'h54, 7'h73, 7'h50, 7'h5C, 7'h78,
                7'h1C, 7'h6D, 7'h40, 7'h08, 7'h00, 7'h00, 7'h00, 7'h00};

    reset_for(3);

    codes = {5'd16, 5'd14, 5'd18, 5'd20};
    dp_in = 4'b0000;
    repeat (3 * FR) step("hello");

    for (int i = 0; i < FR && (n % FR) != 5; i++) step("align1");
    codes = {5'd31, 5'd12, 5'd18, 5'd21};
    repeat (2 * FR + 3) step("midchg");

    dp_in = 4'b0001;
    for (int c = 0; c < 32; c++) begin
      codes = {15'($urandom), 5'(c)};
      repeat (FR) step("sweep");
    end

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(7) == 0) codes = 20'($urandom);
      if ($urandom_range(15) == 0) dp_in = 4'($urandom);
      if ($urandom_range(31) == 0) mask = 4'($urandom);
      step("rand");
    end

    mask = 4'b1000;
    codes = 20'($urandom);
    repeat (9 * FR) step("blink");

    for (int i = 0; i < FR && ((n - 1) / SD) % 4 != 2; i++) step("align2");
    step("pre_rst");
    reset_for(1);
    repeat (2 * FR) step("post_rst");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
